// File: rtl/clb_local_xbar_dbuf.sv
// clb_local_xbar_dbuf: CLB local crossbar whose select config is shifted into a shadow
// register and committed to an active register, so routing continues during reloads.
module clb_local_xbar_dbuf #(
    parameter int N_FLE = 4,
    parameter int FLE_K = 4,
    parameter int FLE_O = 2,
    parameter int CLB_I = 12,
    localparam int NSRC = CLB_I + N_FLE * FLE_O,
    localparam int SEL_W = $clog2(NSRC),
    localparam int NMUX = N_FLE * FLE_K,
    localparam int CFG_BITS = NMUX * SEL_W,
    localparam int CW = $clog2(CFG_BITS + 1)
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   ccff_en,
    input  logic                   ccff_head,
    input  logic                   cfg_commit,
    input  logic [CLB_I-1:0]       clb_I,
    input  logic [N_FLE*FLE_O-1:0] fle_out,
    output logic [NMUX-1:0]        fle_in,
    output logic                   ccff_tail,
    output logic [CW-1:0]          cfg_cnt,
    output logic                   cfg_full,
    output logic                   cfg_valid,
    output logic [1:0]             cfg_err
);
    typedef enum logic [1:0] {EMPTY, LOAD, FULL} state_t;
    state_t state;
    logic [CFG_BITS-1:0] shadow, active;
    logic [NSRC-1:0] src;
    logic bad;
    assign src = {fle_out, clb_I};
    assign ccff_tail = shadow[CFG_BITS-1];
    assign cfg_full = cfg_cnt == CW'(CFG_BITS);
    always_comb begin
        fle_in = '0;
        bad = 1'b0;
        for (int m = 0; m < NMUX; m++) begin
            fle_in[m] = cfg_valid && int'(active[m*SEL_W +: SEL_W]) < NSRC
                        && src[active[m*SEL_W +: SEL_W]];
            bad = bad | (int'(shadow[m*SEL_W +: SEL_W]) >= NSRC);
        end
    end
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            shadow <= '0;
            active <= '0;
            cfg_cnt <= '0;
            cfg_valid <= 1'b0;
            cfg_err <= 2'b00;
            state <= EMPTY;
        end else if (cfg_commit && state == FULL) begin
            // commit wins over a simultaneous shift; shadow is kept as-is
            active <= shadow;
            cfg_valid <= 1'b1;
            cfg_cnt <= '0;
            state <= EMPTY;
            if (bad) cfg_err[1] <= 1'b1;
        end else begin
            if (cfg_commit) cfg_err[0] <= 1'b1;
            if (ccff_en) begin
                shadow <= {shadow[CFG_BITS-2:0], ccff_head};
                if (!cfg_full) cfg_cnt <= cfg_cnt + 1'b1;
                state <= (int'(cfg_cnt) >= CFG_BITS - 1) ? FULL : LOAD;
            end
        end
    end
endmodule
